// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one bit per clock
// Uses a single full_subtractor cell; throughput one result per WIDTH+1 clocks.

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             fs_d, fs_bout;
  logic             accept, last_bit;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign accept   = start && (state_q != S_SHIFT);
  assign last_bit = (state_q == S_SHIFT) && (cnt == CW'(WIDTH - 1));
  assign res_next = {fs_d, res_sh[WIDTH-1:1]};

  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy  = (state_q == S_SHIFT);
  assign done  = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = accept ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      borrow <= bin;
      cnt    <= '0;
    end else if (state_q == S_SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_next;
      borrow <= fs_bout;
      cnt    <= cnt + CW'(1);
      // Result registers only move on the final bit so they hold between done pulses.
      if (last_bit) begin
        diff <= res_next;
        bout <= fs_bout;
        zero <= (res_next == '0);
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
// Directed and random operations compared against plain-arithmetic expectations.

module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk, rst_n, start, bin;
  logic [W-1:0] a, b;
  logic         ready, busy, done, bout, zero;
  logic [W-1:0] diff;
  int           total, bad;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_diff(input int av, input int bv, input int bi);
    int r;
    r = av - bv - bi;
    return W'(r);
  endfunction

  function automatic logic model_bout(input int av, input int bv, input int bi);
    return av < (bv + bi);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_busy"},  busy,  0);
    check({tag, "_done"},  done,  0);
    check({tag, "_diff"},  diff,  0);
    check({tag, "_bout"},  bout,  0);
    check({tag, "_zero"},  zero,  0);
  endtask

  // Waits for done; returns number of edges after acceptance and count of busy samples seen.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 3 * W; i++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = i;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bi);
    int cyc, bc;
    logic [W-1:0] ed;
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~av; b = ~bv; bin = ~bi;
    check({tag, "_busy0"}, busy, 1);
    check({tag, "_ready0"}, ready, 0);
    wait_done(cyc, bc);
    check({tag, "_latency"}, cyc, W);
    check({tag, "_busycnt"}, bc, W - 1);
    ed = model_diff(int'(av), int'(bv), int'(bi));
    check({tag, "_diff"}, diff, ed);
    check({tag, "_bout"}, bout, model_bout(int'(av), int'(bv), int'(bi)));
    check({tag, "_zero"}, zero, ed == 0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_hold"}, diff, ed);
  endtask

  initial begin
    int cyc, bc;
    logic [W-1:0] ra, rb;
    logic rbi;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("basic",     8'h5A, 8'h3C, 1'b0);
    run_op("underflow", 8'h10, 8'h20, 1'b0);
    run_op("bin_edge",  8'h00, 8'h00, 1'b1);
    run_op("equal",     8'h3C, 8'h3C, 1'b0);
    run_op("max_min",   8'hFF, 8'h00, 1'b1);

    // Back-to-back: start held high.
    @(negedge clk);
    a = 8'hFF; b = 8'h01; bin = 1'b0; start = 1'b1;
    wait_done(cyc, bc);
    check("b2b_first_lat", cyc, W + 1);
    check("b2b_first_diff", diff, model_diff(255, 1, 0));
    for (int k = 0; k < 2; k++) begin
      wait_done(cyc, bc);
      check("b2b_period", cyc, W + 1);
      check("b2b_diff", diff, model_diff(255, 1, 0));
      check("b2b_bout", bout, 0);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;
    check("b2b_idle_ready", ready, 1);

    // Start pulsed while busy must be ignored.
    @(negedge clk);
    a = 8'h77; b = 8'h12; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h01; b = 8'hF0; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bc);
    check("ignore_lat", cyc, W - 3);
    check("ignore_diff", diff, model_diff(8'h77, 8'h12, 1));
    check("ignore_bout", bout, model_bout(8'h77, 8'h12, 1));
    @(posedge clk); #1;
    check("ignore_no_requeue", busy, 0);

    // Reset while at bit 4 of a shift.
    @(negedge clk);
    a = 8'hC3; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(cyc, bc);
    check("midreset_no_done", cyc, -1);
    check("midreset_no_busy", bc, 0);
    run_op("post_reset", 8'h80, 8'h7F, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = (n % 6 == 0) ? ra : W'($urandom);
      rbi = 1'($urandom);
      run_op("rand", ra, rb, rbi);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor that computes diff = a - b - bin, LSB first, one bit per clock.
- Upstream/downstream neighbour of the single-bit full_subtractor cell. It instantiates exactly one full_subtractor.
- Each cycle it feeds that cell the current operand bits and the stored borrow, then consumes D and Bout into a result shift register and a borrow flip-flop.
- Sits in the arithmetic datapath where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new subtraction; sampled on rising clk when ready=1
- a  input  WIDTH  minuend; sampled with accepted start
- b  input  WIDTH  subtrahend; sampled with accepted start
- bin  input  1  initial borrow-in; sampled with accepted start
- ready  output  1  high when start will be accepted (state IDLE or DONE)
- busy  output  1  high while bits are being processed (state SHIFT)
- done  output  1  one-cycle pulse: diff/bout/zero just updated
- diff  output  WIDTH  registered result a - b - bin, modulo 2^WIDTH
- bout  output  1  final borrow-out: 1 when a < b + bin, unsigned
- zero  output  1  1 when diff == 0

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of clk:
  - state = IDLE; ready = 1; busy = 0; done = 0.
  - diff = 0; bout = 0; zero = 0.
  - Internal shift registers, borrow flip-flop and bit counter = 0.
- Reset release: the first accepted start is on the first rising edge with rst_n high.
- States:
  - IDLE: ready = 1.
  - SHIFT: busy = 1, ready = 0.
  - DONE: done = 1, ready = 1.
- IDLE, start = 1 at edge E0:
  - Latch a into a_sh, b into b_sh, bin into the borrow flip-flop.
  - Clear the counter; go to SHIFT.
- SHIFT, edges E1..EWIDTH, one bit per edge:
  - The full_subtractor cell takes A = a_sh[0], B = b_sh[0], Bin = borrow.
  - a_sh and b_sh shift right by one.
  - D enters the MSB of the result shift register, which also shifts right.
  - borrow <= Bout; counter increments.
- Final shift (counter == WIDTH-1), at edge EWIDTH:
  - diff <= the completed result; bout <= the final Bout; zero <= (completed result == 0).
  - State goes to DONE.
- Latency: done is high in the cycle that follows EWIDTH, i.e. WIDTH clocks after the edge that accepted start.
- DONE:
  - done is high for exactly one cycle.
  - Next edge goes to IDLE if start = 0.
  - If start = 1 on that edge, the new operands are latched and the state goes straight to SHIFT (back-to-back; throughput one result per WIDTH+1 clocks).
- start while busy = 1: ignored. In-flight operands are unaffected; no queuing.
- a, b, bin may change freely after acceptance; they are sampled only at the accepting edge.
- diff, bout, zero hold their value between done pulses and change only on the final-shift edge.
- Reset mid-SHIFT: the operation is abandoned and no done pulse is produced; outputs take their reset values.
- Arithmetic: unsigned, modulo 2^WIDTH.
  - diff = (a - b - bin) mod 2^WIDTH.
  - bout equals the borrow out of the MSB stage.
  - No signed overflow flag.
- Counter width: the minimum needed to hold WIDTH-1.

Test Plan:
- Reset check (WIDTH=8): assert rst_n low mid-clock -> immediately ready=1, busy=0, done=0, diff=0x00, bout=0, zero=0.
- Basic subtract: a=0x5A, b=0x3C, bin=0, pulse start -> busy high for 8 cycles, then done pulse with diff=0x1E, bout=0, zero=0.
- Underflow: a=0x10, b=0x20, bin=0 -> diff=0xF0, bout=1, zero=0.
- Borrow-in at the boundary: a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0x3C, b=0x3C, bin=0 -> diff=0x00, bout=0, zero=1.
- Handshake edges:
  - Hold start=1 continuously with a=0xFF, b=0x01 -> results every 9 clocks, diff=0xFE, bout=0.
  - Change a/b and pulse start while busy -> result unchanged.
- Reset mid-operation: assert rst_n low at SHIFT bit 4 -> no done pulse; outputs at reset values. After release, a=0x80, b=0x7F -> diff=0x01, bout=0.
